muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO unit that executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO, issued by the ALU control encodings.
- Iterative shift-add multiplier and restoring divider, run by an FSM.
- Owns the HI and LO registers. Raises oBusy so the CPU control stalls MFHI/MFLO and further HI/LO ops until the result is committed.

Parameters:
- MUL_BITS, 1, multiplier bits retired per iteration. Legal values 1, 2, 4. Multiply iterations = 32/MUL_BITS.
- DIV_ITERS, 32, divide iterations (fixed, 1 quotient bit per cycle). Not for override.

Ports:
- iCLK  in  1  system clock, rising edge
- iRST  in  1  asynchronous reset, active-low
- iStart  in  1  issue strobe, sampled only in IDLE
- iOp  in  5  ALU control code (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMADD, OPMADDU, OPMSUB, OPMSUBU, OPMTHI, OPMTLO)
- iA  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- iB  in  32  rt operand (divisor / multiplier)
- iFlush  in  1  abort the in-flight operation (pipeline flush)
- oBusy  out  1  operation in flight; HI/LO not valid
- oDone  out  1  one-cycle pulse: HI/LO committed on the previous edge
- oDivZero  out  1  one-cycle pulse coincident with oDone when the divisor was 0
- oHI  out  32  HI register
- oLO  out  32  LO register

Behaviour:
- Reset (iRST=0, async): state IDLE; oHI=oLO=0; oBusy=oDone=oDivZero=0; all working registers 0.
- States:
  - IDLE: accepts iStart.
  - MUL: one iteration per cycle, retires MUL_BITS bits.
  - DIV: one restoring step per cycle.
  - FIX: applies sign correction, applies accumulate/subtract, commits HI/LO.
- IDLE with iStart=1:
  - MTHI/MTLO: oHI or oLO takes iA at that edge, no busy. oDone pulses the next cycle.
  - Multiply ops: latch |iA| and |iB| (raw for unsigned ops), record the result sign, go to MUL.
  - Divide ops with iB!=0: same latching, go to DIV.
  - Divide ops with iB==0: go straight to FIX.
  - Unrecognised iOp: ignored, stays IDLE.
- Latency, default parameters:
  - Multiply: 32 MUL cycles + 1 FIX cycle. oBusy is high for 33 cycles starting the cycle after issue; oDone rises with oBusy falling.
  - Divide: 32 DIV + 1 FIX, same timing.
  - Divide by zero: 1 FIX cycle. Commits HI=iA and LO=32'hFFFFFFFF, and pulses oDivZero with oDone.
- FIX rules:
  - MULT/MULTU: {HI,LO} = 64-bit product; two's-complement negate if the sign flag is set.
  - MADD/MADDU: {HI,LO} += product. MSUB/MSUBU: {HI,LO} -= product. Both are modulo 2^64.
  - The accumulate base is the HI/LO value at issue time.
  - DIV: LO = quotient, negated if operand signs differ. HI = remainder, carrying the sign of the dividend.
  - DIV of 32'h80000000 by 32'hFFFFFFFF: LO=32'h80000000, HI=0 (wraps, no trap).
  - DIVU: unsigned, no sign handling.
- oHI/oLO change only at the FIX edge or at MTHI/MTLO. They hold their old values throughout MUL/DIV.
- iStart while oBusy=1: ignored, no queueing. The CPU control must stall the issue.
- iFlush=1 in MUL/DIV/FIX: return to IDLE next edge. HI/LO keep their pre-issue values. No oDone, no oDivZero.
- iFlush=1 and iStart=1 together in IDLE: flush wins, nothing issued.
- iFlush=1 during an MTHI/MTLO issue edge: write suppressed.
- Reset asserted mid-operation: immediate IDLE and zeroed HI/LO, as at power-up.
- oDone and oDivZero are never high for more than one consecutive cycle.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX on the next edge, after shifting the partial product into its final position.
  - Example: MULTU 5x3 takes 2 MUL cycles + FIX, so oBusy lasts 3 cycles.
  - DIV latency is unchanged.
- Undefined: multiply latency is fixed at 32/MUL_BITS + 1 cycles.

Test Plan:
- MULT iA=32'hFFFFFFFD (-3), iB=7 -> after 33 busy cycles oHI=32'hFFFFFFFF, oLO=32'hFFFFFFEB, oDone pulses once.
- MTHI iA=1, MTLO iA=2, then MADDU iA=32'hFFFFFFFF, iB=2 -> oHI=3, oLO=0 after 33 cycles.
- DIV iA=-7, iB=2 -> oLO=32'hFFFFFFFD, oHI=32'hFFFFFFFF. Then DIVU iA=100, iB=0 -> next cycle oHI=100, oLO=32'hFFFFFFFF, oDivZero=1 with oDone.
- Issue MULTU 10x10, assert iFlush at busy cycle 5 -> oBusy=0 next cycle, no oDone, oHI/oLO keep pre-issue values. Then iStart with iFlush together in IDLE -> nothing issued.
- Issue DIV, pulse iStart with a different op at busy cycle 10 -> ignored, original result committed. Drop iRST at busy cycle 20 -> oHI=oLO=0, oBusy=0 immediately.
- MUL_BITS=4, MULT 6x(-4) -> 8 MUL cycles + FIX, oBusy high 9 cycles, {oHI,oLO}=64'hFFFFFFFFFFFFFFE8. With MULDIV_EARLY_TERM_EN defined and MUL_BITS=1, MULTU 5x3 -> oBusy high 3 cycles, oLO=15.

Source files
------------

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle HI/LO unit: iterative shift-add multiply, restoring
//            divide, MADD/MSUB accumulate and MTHI/MTLO. Optional feature
//            macro MULDIV_EARLY_TERM_EN enables multiply early termination.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int MUL_BITS  = 1,
    parameter int DIV_ITERS = 32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [4:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iFlush,
    output logic        oBusy,
    output logic        oDone,
    output logic        oDivZero,
    output logic [31:0] oHI,
    output logic [31:0] oLO
);

    localparam logic [4:0] c_op_mult  = 5'h10;
    localparam logic [4:0] c_op_multu = 5'h11;
    localparam logic [4:0] c_op_div   = 5'h12;
    localparam logic [4:0] c_op_divu  = 5'h13;
    localparam logic [4:0] c_op_madd  = 5'h14;
    localparam logic [4:0] c_op_maddu = 5'h15;
    localparam logic [4:0] c_op_msub  = 5'h16;
    localparam logic [4:0] c_op_msubu = 5'h17;
    localparam logic [4:0] c_op_mthi  = 5'h18;
    localparam logic [4:0] c_op_mtlo  = 5'h19;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_fix  = 2'd3;

    localparam int         c_mul_iters = 32 / MUL_BITS;
    localparam logic [5:0] c_mul_last  = 6'(c_mul_iters - 1);
    localparam logic [5:0] c_div_last  = 6'(DIV_ITERS - 1);

    logic [1:0]  r_state;
    logic [4:0]  r_op;
    logic        r_neg;
    logic        r_rem_neg;
    logic        r_dz;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dz_pulse;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic        w_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_pp;
    logic [31:0] w_mplier_nxt;
    logic        w_mul_last;
    logic [32:0] w_trial;
    logic [63:0] w_div_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_fix;

    always_comb begin
        w_is_mul = iOp inside {c_op_mult, c_op_multu, c_op_madd, c_op_maddu,
                               c_op_msub, c_op_msubu};
        w_is_div = iOp inside {c_op_div, c_op_divu};
        w_signed = iOp inside {c_op_mult, c_op_div, c_op_madd, c_op_msub};
        w_a_mag  = (w_signed && iA[31]) ? (32'd0 - iA) : iA;
        w_b_mag  = (w_signed && iB[31]) ? (32'd0 - iB) : iB;
        w_neg    = w_signed & (iA[31] ^ iB[31]);
    end

    // Multiplicand shifts left, multiplier right: the accumulator is always in
    // final position, so stopping early needs no realignment.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
        end
        w_mplier_nxt = r_mplier >> MUL_BITS;
    end

`ifdef MULDIV_EARLY_TERM_EN
    assign w_mul_last = (r_cnt == c_mul_last) || (w_mplier_nxt == 32'd0);
`else
    assign w_mul_last = (r_cnt == c_mul_last);
`endif

    // Restoring step: r_acc holds {remainder, dividend/quotient}.
    always_comb begin
        w_trial = r_acc[63:31] - {1'b0, r_mcand[31:0]};
        if (!w_trial[32]) w_div_nxt = {w_trial[31:0], r_acc[30:0], 1'b1};
        else              w_div_nxt = {r_acc[62:0], 1'b0};
    end

    always_comb begin
        w_prod = r_neg ? (64'd0 - r_acc) : r_acc;
        w_quo  = r_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem  = r_rem_neg ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        w_fix  = {r_hi, r_lo};
        case (r_op)
            c_op_mult, c_op_multu: w_fix = w_prod;
            c_op_madd, c_op_maddu: w_fix = {r_hi, r_lo} + w_prod;
            c_op_msub, c_op_msubu: w_fix = {r_hi, r_lo} - w_prod;
            c_op_div, c_op_divu:   w_fix = r_dz ? {r_acc[31:0], 32'hFFFF_FFFF}
                                                : {w_rem, w_quo};
            default:               w_fix = {r_hi, r_lo};
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state    <= c_st_idle;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_dz       <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dz_pulse <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_dz_pulse <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (iStart && !iFlush) begin
                        // Back-to-back moves commit, but oDone never stretches.
                        if (iOp == c_op_mthi) begin
                            r_hi   <= iA;
                            r_done <= ~r_done;
                        end else if (iOp == c_op_mtlo) begin
                            r_lo   <= iA;
                            r_done <= ~r_done;
                        end else if (w_is_mul || w_is_div) begin
                            r_op      <= iOp;
                            r_neg     <= w_neg;
                            r_rem_neg <= w_signed & iA[31];
                            r_cnt     <= '0;
                            r_dz      <= 1'b0;
                            if (w_is_div && iB == 32'd0) begin
                                r_dz    <= 1'b1;
                                r_acc   <= {32'd0, iA};
                                r_state <= c_st_fix;
                            end else if (w_is_div) begin
                                r_acc   <= {32'd0, w_a_mag};
                                r_mcand <= {32'd0, w_b_mag};
                                r_state <= c_st_div;
                            end else begin
                                r_acc    <= '0;
                                r_mcand  <= {32'd0, w_a_mag};
                                r_mplier <= w_b_mag;
                                r_state  <= c_st_mul;
                            end
                        end
                    end
                end
                c_st_mul: begin
                    if (iFlush) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_acc    <= r_acc + w_pp;
                        r_mcand  <= r_mcand << MUL_BITS;
                        r_mplier <= w_mplier_nxt;
                        r_cnt    <= r_cnt + 6'd1;
                        if (w_mul_last) r_state <= c_st_fix;
                    end
                end
                c_st_div: begin
                    if (iFlush) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_acc <= w_div_nxt;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_div_last) r_state <= c_st_fix;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    if (!iFlush) begin
                        r_hi       <= w_fix[63:32];
                        r_lo       <= w_fix[31:0];
                        r_done     <= 1'b1;
                        r_dz_pulse <= r_dz;
                    end
                end
            endcase
        end
    end

    assign oBusy    = (r_state != c_st_idle);
    assign oDone    = r_done;
    assign oDivZero = r_dz_pulse;
    assign oHI      = r_hi;
    assign oLO      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Directed self-checking bench for muldiv_sequencer (default and
//            MUL_BITS=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MADDU = 5'h15;
    localparam logic [4:0] OP_MSUB  = 5'h16;
    localparam logic [4:0] OP_MTHI  = 5'h18;
    localparam logic [4:0] OP_MTLO  = 5'h19;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    logic        start4, flush4;
    logic [4:0]  op4;
    logic [31:0] a4, b4;
    logic        busy4, done4, dz4;
    logic [31:0] hi4, lo4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer u_dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .iOp(op), .iA(a), .iB(b),
        .iFlush(flush), .oBusy(busy), .oDone(done), .oDivZero(dz),
        .oHI(hi), .oLO(lo)
    );

    muldiv_sequencer #(.MUL_BITS(4)) u_dut4 (
        .iCLK(clk), .iRST(rst), .iStart(start4), .iOp(op4), .iA(a4), .iB(b4),
        .iFlush(flush4), .oBusy(busy4), .oDone(done4), .oDivZero(dz4),
        .oHI(hi4), .oLO(lo4)
    );

    // Expected busy length of a multiply for multiplier magnitude m.
    function automatic int exp_mul_busy(input logic [31:0] m, input int bits);
        int n;
        logic [31:0] r;
        n = 1;
        r = m >> bits;
        while (r != 32'd0 && n < 32 / bits) begin
            n++;
            r = r >> bits;
        end
`ifndef MULDIV_EARLY_TERM_EN
        n = 32 / bits;
`endif
        return n + 1;
    endfunction

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n, output logic d_end, output logic z_end, output logic d_after);
        issue(o, x, y);
        wait_idle(n);
        d_end = done;
        z_end = dz;
        @(negedge clk);
        d_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        start4 = 1'b0; flush4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
        #2 rst = 1'b0;
        #20;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_divzero: got %b expected 0", dz); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mult();
        int n; logic de, ze, da;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, n, de, ze, da);
        checks++; if (n != exp_mul_busy(32'd7, 1)) begin errors++; $display("FAIL mult_busy: got %0d expected %0d", n, exp_mul_busy(32'd7, 1)); end
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL mult_done: got %b expected 1", de); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL mult_done_width: got %b expected 0", da); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFEB); end

        run_op(OP_MULTU, 32'd5, 32'd3, n, de, ze, da);
        checks++; if (n != exp_mul_busy(32'd3, 1)) begin errors++; $display("FAIL multu_busy: got %0d expected %0d", n, exp_mul_busy(32'd3, 1)); end
        checks++; if (lo !== 32'd15 || hi !== 32'd0) begin errors++; $display("FAIL multu_result: got %h_%h expected 00000000_0000000f", hi, lo); end

        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, n, de, ze, da);
        checks++; if (hi !== 32'h4000_0000 || lo !== 32'd0) begin errors++; $display("FAIL mult_minneg: got %h_%h expected 40000000_00000000", hi, lo); end
    endtask

    task automatic test_accumulate();
        int n; logic de, ze, da;
        issue(OP_MTHI, 32'd1, 32'd0);
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mthi_flags: got busy=%b done=%b expected busy=0 done=1", busy, done); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL mthi_hi: got %h expected %h", hi, 32'd1); end
        issue(OP_MTLO, 32'd2, 32'd0);
        checks++; if (lo !== 32'd2 || hi !== 32'd1) begin errors++; $display("FAIL mtlo_hilo: got %h_%h expected 00000001_00000002", hi, lo); end

        run_op(OP_MADDU, 32'hFFFF_FFFF, 32'd2, n, de, ze, da);
        checks++; if (n != exp_mul_busy(32'd2, 1)) begin errors++; $display("FAIL maddu_busy: got %0d expected %0d", n, exp_mul_busy(32'd2, 1)); end
        checks++; if (hi !== 32'd3 || lo !== 32'd0) begin errors++; $display("FAIL maddu_result: got %h_%h expected 00000003_00000000", hi, lo); end

        run_op(OP_MSUB, 32'd2, 32'hFFFF_FFFF, n, de, ze, da);
        checks++; if (hi !== 32'd3 || lo !== 32'd2) begin errors++; $display("FAIL msub_result: got %h_%h expected 00000003_00000002", hi, lo); end
    endtask

    task automatic test_divide();
        int n; logic de, ze, da;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n, de, ze, da);
        checks++; if (n != 33) begin errors++; $display("FAIL div_busy: got %0d expected 33", n); end
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_result: got %h_%h expected ffffffff_fffffffd", hi, lo); end
        checks++; if (ze !== 1'b0) begin errors++; $display("FAIL div_divzero: got %b expected 0", ze); end

        run_op(OP_DIVU, 32'd100, 32'd0, n, de, ze, da);
        checks++; if (n != 1) begin errors++; $display("FAIL divz_busy: got %0d expected 1", n); end
        checks++; if (de !== 1'b1 || ze !== 1'b1) begin errors++; $display("FAIL divz_flags: got done=%b divzero=%b expected 1 1", de, ze); end
        checks++; if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_result: got %h_%h expected 00000064_ffffffff", hi, lo); end
        checks++; if (da !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL divz_pulse_width: got done=%b divzero=%b expected 0 0", da, dz); end

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, de, ze, da);
        checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin errors++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", hi, lo); end

        run_op(OP_DIVU, 32'd100, 32'd7, n, de, ze, da);
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_result: got %h_%h expected 00000002_0000000e", hi, lo); end

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n, de, ze, da);
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin errors++; $display("FAIL div_negdivisor: got %h_%h expected 00000001_fffffffd", hi, lo); end
    endtask

    task automatic test_flush();
        issue(OP_MULTU, 32'd10, 32'd10);
        for (int k = 1; k < 5; k++) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_prebusy: got %b expected 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_flags: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL flush_hilo: got %h_%h expected 00000001_fffffffd", hi, lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_late_done: got %b expected 0", done); end

        start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_issue: got busy=%b done=%b expected 0 0", busy, done); end

        start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'h55;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (hi !== 32'd1 || done !== 1'b0) begin errors++; $display("FAIL flush_mthi: got hi=%h done=%b expected 00000001 0", hi, done); end
    endtask

    task automatic test_ignore_and_reset();
        int n;
        issue(OP_DIV, 32'd1000, 32'd3);
        for (int k = 1; k < 10; k++) @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        checks++; if (n + 10 != 33) begin errors++; $display("FAIL ignore_busy: got %0d expected 33", n + 10); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b expected 1", done); end
        checks++; if (hi !== 32'd1 || lo !== 32'd333) begin errors++; $display("FAIL ignore_result: got %h_%h expected 00000001_0000014d", hi, lo); end

        issue(OP_DIV, 32'd1000, 32'd3);
        for (int k = 1; k < 20; k++) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo: got %h_%h expected 00000000_00000000", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL postreset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mulbits4();
        int n;
        @(negedge clk);
        start4 = 1'b1; op4 = OP_MULT; a4 = 32'd6; b4 = 32'hFFFF_FFFC;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (busy4 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != exp_mul_busy(32'd4, 4)) begin errors++; $display("FAIL mb4_busy: got %0d expected %0d", n, exp_mul_busy(32'd4, 4)); end
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL mb4_done: got %b expected 1", done4); end
        checks++; if (hi4 !== 32'hFFFF_FFFF || lo4 !== 32'hFFFF_FFE8) begin errors++; $display("FAIL mb4_result: got %h_%h expected ffffffff_ffffffe8", hi4, lo4); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_accumulate();
        test_divide();
        test_flush();
        test_ignore_and_reset();
        test_mulbits4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
